// File: rtl/seq_det_pkg.sv
// Shared types for the sequence-detector scheduler: FSM states, requester ID
// and the result-count width derivation.
package seq_det_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StClr   = 2'd1,
    StShift = 2'd2,
    StDone  = 2'd3
  } sched_state_e;

  typedef logic req_id_t;

  // Width needed to hold a hit count in 0..w.
  function automatic int unsigned cw_of(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_det_sched_if.sv
// Bundle of requester handshakes, detector link and result signals.
// master = producers/detector/consumer side, slave = scheduler side.
interface seq_det_sched_if #(
  parameter int unsigned W = 8
) ();
  import seq_det_pkg::*;

  localparam int unsigned CW = cw_of(W);

  logic          req0_valid;
  logic [W-1:0]  req0_data;
  logic          req0_ack;
  logic          req1_valid;
  logic [W-1:0]  req1_data;
  logic          req1_ack;
  logic          det_clr;
  logic          det_x;
  logic          det_z;
  logic          res_valid;
  req_id_t       res_id;
  logic [CW-1:0] res_count;
  logic          busy;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, det_z,
    input  req0_ack, req1_ack, det_clr, det_x, res_valid, res_id, res_count, busy
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, det_z,
    output req0_ack, req1_ack, det_clr, det_x, res_valid, res_id, res_count, busy
  );

endinterface

// File: rtl/seq_det_sched_rr_arb2.sv
// Two-input round-robin arbiter; the pointer flips to the loser after each grant.
module rr_arb2
  import seq_det_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic       gnt_o,
  output req_id_t    gnt_id_o
);

  req_id_t ptr_q;

  always_comb begin
    gnt_o    = en_i & (|req_i);
    // Pointer only matters on contention; a lone requester always wins.
    gnt_id_o = (&req_i) ? ptr_q : req_i[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (gnt_o) begin
      ptr_q <= ~gnt_id_o;
    end
  end

endmodule

// File: rtl/seq_det_sched.sv
// Shares one serial Mealy detector between two word requesters: grant, clear the
// detector, shift the word MSB-first, count hits and report count with the ID.
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input logic             clk,
  input logic             rst,
  seq_det_sched_if.slave  bus
);

  localparam int unsigned CW = cw_of(W);
  localparam int unsigned BW = $clog2(W);

  sched_state_e  state_q;
  logic [W-1:0]  word_q;
  logic [BW-1:0] bitcnt_q;
  logic [CW-1:0] hits_q;
  req_id_t       id_q;
  logic          ack0_q, ack1_q, clr_q, res_valid_q, busy_q;
  req_id_t       res_id_q;
  logic [CW-1:0] res_count_q;

  logic          arb_en, arb_gnt;
  req_id_t       arb_id;
  logic [CW-1:0] hits_inc;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .en_i     (arb_en),
    .req_i    ({bus.req1_valid, bus.req0_valid}),
    .gnt_o    (arb_gnt),
    .gnt_id_o (arb_id)
  );

  // Grants are decided on the edge entering IDLE so the ack pulse sits in IDLE;
  // no new grant while an ack is still outstanding.
  always_comb begin
    arb_en   = ((state_q == StIdle) && !(ack0_q || ack1_q)) || (state_q == StDone);
    hits_inc = hits_q + CW'(bus.det_z);
    bus.det_x = 1'b0;
    if (state_q == StShift) begin
      bus.det_x = word_q[BW'(W - 1) - bitcnt_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      word_q      <= '0;
      bitcnt_q    <= '0;
      hits_q      <= '0;
      id_q        <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      clr_q       <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      res_id_q    <= 1'b0;
      res_count_q <= '0;
    end else begin
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      clr_q       <= 1'b0;
      res_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (ack0_q || ack1_q) begin
            // Ack cycle: the granted requester's data is stable now.
            word_q  <= id_q ? bus.req1_data : bus.req0_data;
            clr_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StClr;
          end else if (arb_gnt) begin
            ack0_q <= ~arb_id;
            ack1_q <= arb_id;
            id_q   <= arb_id;
          end
        end
        StClr: begin
          bitcnt_q <= '0;
          hits_q   <= '0;
          state_q  <= StShift;
        end
        StShift: begin
          hits_q   <= hits_inc;
          bitcnt_q <= bitcnt_q + 1'b1;
          if (bitcnt_q == BW'(W - 1)) begin
            res_valid_q <= 1'b1;
            res_id_q    <= id_q;
            res_count_q <= hits_inc;
            state_q     <= StDone;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
          if (arb_gnt) begin
            ack0_q <= ~arb_id;
            ack1_q <= arb_id;
            id_q   <= arb_id;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req0_ack  = ack0_q;
  assign bus.req1_ack  = ack1_q;
  assign bus.det_clr   = clr_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_count = res_count_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/seq_det_sched.md
# seq_det_sched

Scheduler that shares one serial Mealy sequence detector between two word-level requesters. It accepts W-bit words over a valid/ack handshake and arbitrates round-robin. It clears the detector, shifts the granted word in MSB-first one bit per clock, counts detector hits, and reports the count with the requester ID. It sits between the parallel producers and the single-bit detector core, which is the only block that knows the target pattern.

## Interface
- W, default 8, data word width; W ≥ 2.
- CW, default $clog2(W+1), result count width; derived, not to be overridden.

- clk, in, 1, single system clock; all logic on posedge.
- rst, in, 1, synchronous, active-high reset.
- req0_valid, in, 1, requester 0 has a word.
- req0_data, in, W, requester 0 word.
- req0_ack, out, 1, one-cycle grant/accept pulse to requester 0.
- req1_valid, in, 1, requester 1 has a word.
- req1_data, in, W, requester 1 word.
- req1_ack, out, 1, one-cycle grant/accept pulse to requester 1.
- det_clr, out, 1, one-cycle detector clear (detector returns to its idle state).
- det_x, out, 1, serial bit to the detector.
- det_z, in, 1, detector Mealy output; combinational on the current det_x.
- res_valid, out, 1, one-cycle result strobe.
- res_id, out, 1, requester whose word produced the result.
- res_count, out, CW, number of cycles with det_z=1 during the shift.
- busy, out, 1, high in every state except IDLE.

## Operation
- States: IDLE, CLR, SHIFT, DONE.
- IDLE:
  - If any reqN_valid is high, grant one requester, pulse its reqN_ack, latch its data, id ← N, and go to CLR.
  - Otherwise stay in IDLE.
- Arbitration:
  - A round-robin pointer selects the requester when both are valid.
  - The pointer resets to 0.
  - After each grant the pointer moves to the other requester.
  - With a single valid requester, that requester is granted regardless of the pointer.
- CLR:
  - det_clr=1, det_x=0 for one cycle.
  - Clear the bit counter and the hit counter.
  - Go to SHIFT.
- SHIFT:
  - det_x = word[W-1-bitcnt].
  - If det_z=1 in the same cycle, hit counter +1.
  - After W cycles, go to DONE.
- DONE:
  - res_valid=1; res_id and res_count hold the latched values.
  - Go to IDLE.
- Handshake rules:
  - A requester holds valid and data stable until its ack.
  - Data is sampled only in the ack cycle.
  - Valid may stay high after ack to offer the next word.
  - No ack is issued outside IDLE.
- Arithmetic: the hit counter is CW bits wide and cannot overflow, because there are at most W hits.
- Reset at any time:
  - Force IDLE and pointer=0.
  - Drive all outputs to 0: ack, det_clr, det_x, res_valid, res_id, res_count, busy.
  - An in-flight word is dropped silently; no res_valid is issued for it.
- det_x is 0 outside SHIFT. res_id and res_count keep their last values outside DONE and are valid only with res_valid.

## Timing
- Ack in cycle T (IDLE).
- det_clr in T+1.
- Bits in T+2 … T+W+1.
- res_valid in T+W+2.
- Earliest next ack in T+W+3.
- Latency from ack to result: W+2 cycles. Throughput: one word per W+3 cycles.
- All outputs are registered except det_x, which is a combinational mux of registered word and bitcnt.
- det_z is sampled on the edge that ends each SHIFT cycle.

## Structure
- Shared package seq_det_pkg holds:
  - the state enum: IDLE=0, CLR=1, SHIFT=2, DONE=3;
  - the requester ID type;
  - the CW derivation function.
- Sub-module rr_arb2 is a two-input round-robin arbiter: pointer register, grant-on-enable, pointer update on grant.
- The scheduler FSM, shift register, bit counter and hit counter stay in seq_det_sched.

## Test plan
The bench detector model is an overlapping Mealy detector for 100100, where z=1 on the final 0. W=8.
- Reset mid-SHIFT (after bit 3) → next cycle: IDLE, all outputs 0, busy=0; no res_valid for that word.
- req0 sends 8'b10010010 → req0_ack at T, det_clr at T+1, hit on bit 6, res_valid at T+10 with res_id=0, res_count=1.
- req0 sends 8'b10010010, then 8'b00000000 back-to-back (req0_valid held) → counts 1 then 0. The second count proves det_clr is issued between words: without it the detector would stay at 10010 and the leading 0 would hit.
- req0 and req1 both valid from reset → grants alternate 0,1,0,1; each ack is exactly W+3 cycles after the previous one.
- req1 alone sends 8'b11001001 → res_id=1, res_count=1; pointer then favours req0.
- Bursts of random words from both requesters → every word yields exactly one result, in grant order; res_count matches a reference-model count; no ack while busy.
